// File: rtl/vga_stats_display_if.sv
// vga_stats_display_if
// Bundles the scan position, counter inputs and pixel/status outputs of the
// statistics display so the VGA sync side and the display can be wired as one bus.
//   x, y    : current scan position from the sync unit
//   counts  : NCH flattened W-bit counters, channel k at [k*W +: W]
//   freeze  : suppress per-frame snapshots
//   rgb     : registered pixel colour
//   busy    : conversion engine active
//   update  : one-cycle pulse when the display buffer is refreshed
interface vga_stats_display_if #(
  parameter int CD  = 12,
  parameter int NCH = 9,
  parameter int W   = 32
);
  logic [10:0]       x;
  logic [10:0]       y;
  logic [NCH*W-1:0]  counts;
  logic              freeze;
  logic [CD-1:0]     rgb;
  logic              busy;
  logic              update;

  modport master (output x, y, counts, freeze, input rgb, busy, update);
  modport slave  (input x, y, counts, freeze, output rgb, busy, update);
endinterface

// File: rtl/vga_stats_display.sv
// vga_stats_display
// Snapshots NCH counters at the start of vertical blanking, converts each to
// BCD with a one-bit-per-cycle double-dabble engine and draws every counter as
// a row of seven-segment decimal digits on the pixel currently being scanned.
//   clk    : system clock, shared with the VGA sync unit
//   reset  : asynchronous, active-high
//   bus    : slave side of vga_stats_display_if (x, y, counts, freeze in;
//            rgb, busy, update out)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for the vertical-blank trigger
// LOAD  | load snapshot channel ch into the shifter, clear BCD
// CONV  | W double-dabble iterations, one per cycle
// STORE | write BCD digits of channel ch into shadow, advance ch
// SWAP  | copy shadow to display, pulse update
module vga_stats_display #(
  parameter int            CD     = 12,
  parameter int            NCH    = 9,
  parameter int            W      = 32,
  parameter int            DIGITS = 10,
  parameter int            HDISP  = 640,
  parameter int            VDISP  = 480,
  parameter int            X0     = 32,
  parameter int            Y0     = 16,
  parameter logic [CD-1:0] FG     = 12'h0F0,
  parameter logic [CD-1:0] BG     = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  vga_stats_display_if.slave bus
);

  localparam int              ITW     = (W > 1) ? $clog2(W) : 1;
  localparam int              BW      = 4 * DIGITS;
  localparam logic [10:0]     X0_L    = 11'(X0);
  localparam logic [10:0]     Y0_L    = 11'(Y0);
  localparam logic [10:0]     HD_L    = 11'(HDISP);
  localparam logic [10:0]     VD_L    = 11'(VDISP);
  localparam logic [3:0]      LAST_CH = 4'(NCH - 1);
  localparam logic [ITW-1:0]  IT_INIT = ITW'(W - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_STORE, S_SWAP} state_t;

  state_t r_state;
  state_t w_next;

  logic [NCH*W-1:0] r_snap;
  logic [W-1:0]     r_sh;
  logic [BW-1:0]    r_bcd;
  logic [ITW-1:0]   r_it;
  logic [3:0]       r_ch;
  logic [BW-1:0]    r_shadow [NCH];
  logic [BW-1:0]    r_disp   [NCH];
  logic             r_prev_at;
  logic [CD-1:0]    r_rgb;

  logic             w_at_trig;
  logic             w_trig;
  logic             w_start;
  logic             w_busy;
  logic             w_update;
  logic [W-1:0]     w_snap_ch;
  logic [BW-1:0]    w_adj;

  // Trigger fires only on entry to (0, VDISP): the pixel tick may be slower
  // than clk, so the position can repeat for several cycles.
  assign w_at_trig = (bus.x == 11'd0) && (bus.y == VD_L);
  assign w_trig    = w_at_trig && !r_prev_at;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trig && !bus.freeze) w_next = S_LOAD;
      S_LOAD:  w_next = S_CONV;
      S_CONV:  if (r_it == '0) w_next = S_STORE;
      S_STORE: w_next = (r_ch == LAST_CH) ? S_SWAP : S_LOAD;
      S_SWAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state != S_IDLE);
    w_update = (r_state == S_SWAP);
    w_start  = (r_state == S_IDLE) && w_trig && !bus.freeze;
  end

  assign bus.busy   = w_busy;
  assign bus.update = w_update;

  // ---------------------------------------------------------- datapath
  always_comb begin
    w_snap_ch = '0;
    for (int k = 0; k < NCH; k++)
      if (r_ch == 4'(k)) w_snap_ch = r_snap[k*W +: W];
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int j = 0; j < DIGITS; j++)
      if (r_bcd[j*4 +: 4] >= 4'd5) w_adj[j*4 +: 4] = r_bcd[j*4 +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snap    <= '0;
      r_sh      <= '0;
      r_bcd     <= '0;
      r_it      <= '0;
      r_ch      <= '0;
      r_prev_at <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_shadow[k] <= '0;
        r_disp[k]   <= '0;
      end
    end else begin
      r_prev_at <= w_at_trig;
      if (w_start) begin
        r_snap <= bus.counts;
        r_ch   <= '0;
      end
      case (r_state)
        S_LOAD: begin
          r_sh  <= w_snap_ch;
          r_bcd <= '0;
          r_it  <= IT_INIT;
        end
        S_CONV: begin
          {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
          r_it          <= r_it - ITW'(1);
        end
        S_STORE: begin
          for (int k = 0; k < NCH; k++)
            if (r_ch == 4'(k)) r_shadow[k] <= r_bcd;
          r_ch <= r_ch + 4'd1;
        end
        S_SWAP: begin
          for (int k = 0; k < NCH; k++) r_disp[k] <= r_shadow[k];
          r_ch <= '0;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------- rendering
  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic [6:0]    w_col;
  logic [3:0]    w_u;
  logic [5:0]    w_row;
  logic [4:0]    w_v;
  logic          w_in_cell;
  logic [BW-1:0] w_rowbits;
  logic [3:0]    w_nib;
  logic          w_lead;
  logic          w_blank;
  logic [6:0]    w_segs;
  logic [6:0]    w_region;
  logic          w_lit;
  logic          w_visible;

  assign w_dx  = bus.x - X0_L;
  assign w_dy  = bus.y - Y0_L;
  assign w_col = w_dx[10:4];
  assign w_u   = w_dx[3:0];
  assign w_row = w_dy[10:5];
  assign w_v   = w_dy[4:0];

  assign w_in_cell = (bus.x >= X0_L) && (bus.y >= Y0_L) &&
                     (w_row < 6'(NCH)) && (w_col < 7'(DIGITS)) && (w_v < 5'd24);

  always_comb begin
    w_rowbits = '0;
    for (int k = 0; k < NCH; k++)
      if (w_row == 6'(k)) w_rowbits = r_disp[k];
  end

  // Column 0 is the most significant digit. w_lead stays set while every
  // digit from the left up to and including this column is zero.
  always_comb begin
    w_nib  = '0;
    w_lead = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((7'(j) <= w_col) && (w_rowbits[(DIGITS-1-j)*4 +: 4] != 4'd0)) w_lead = 1'b0;
      if (w_col == 7'(j)) w_nib = w_rowbits[(DIGITS-1-j)*4 +: 4];
    end
    w_blank = w_lead && (w_col != 7'(DIGITS - 1));
  end

  // Segment order {a,b,c,d,e,f,g}
  always_comb begin
    case (w_nib)
      4'd0:    w_segs = 7'b1111110;
      4'd1:    w_segs = 7'b0110000;
      4'd2:    w_segs = 7'b1101101;
      4'd3:    w_segs = 7'b1111001;
      4'd4:    w_segs = 7'b0110011;
      4'd5:    w_segs = 7'b1011011;
      4'd6:    w_segs = 7'b1011111;
      4'd7:    w_segs = 7'b1110000;
      4'd8:    w_segs = 7'b1111111;
      4'd9:    w_segs = 7'b1111011;
      default: w_segs = 7'b0000000;
    endcase
  end

  always_comb begin
    w_region    = '0;
    w_region[6] = (w_u >= 4'd2) && (w_u <= 4'd13) && (w_v <= 5'd1);
    w_region[5] = (w_u >= 4'd14) && (w_v >= 5'd2) && (w_v <= 5'd10);
    w_region[4] = (w_u >= 4'd14) && (w_v >= 5'd13) && (w_v <= 5'd21);
    w_region[3] = (w_u >= 4'd2) && (w_u <= 4'd13) && (w_v >= 5'd22) && (w_v <= 5'd23);
    w_region[2] = (w_u <= 4'd1) && (w_v >= 5'd13) && (w_v <= 5'd21);
    w_region[1] = (w_u <= 4'd1) && (w_v >= 5'd2) && (w_v <= 5'd10);
    w_region[0] = (w_u >= 4'd2) && (w_u <= 4'd13) && (w_v >= 5'd11) && (w_v <= 5'd12);
  end

  assign w_lit     = w_in_cell && !w_blank && |(w_segs & w_region);
  assign w_visible = (bus.x < HD_L) && (bus.y < VD_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_rgb <= '0;
    else if (w_lit)     r_rgb <= FG;
    else if (w_visible) r_rgb <= BG;
    else                r_rgb <= '0;
  end

  assign bus.rgb = r_rgb;

endmodule

// File: tb/tb_vga_stats_display.sv
module tb_vga_stats_display;
  localparam int          CD     = 12;
  localparam int          NCH    = 9;
  localparam int          W      = 32;
  localparam int          DIGITS = 10;
  localparam int          HDISP  = 640;
  localparam int          VDISP  = 480;
  localparam int          X0     = 32;
  localparam int          Y0     = 16;
  localparam logic [11:0] FG     = 12'h0F0;
  localparam logic [11:0] BG     = 12'h000;
  localparam int          CONV_CYC = NCH * (W + 2);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_stats_display_if #(.CD(CD), .NCH(NCH), .W(W)) bus();

  vga_stats_display #(
    .CD(CD), .NCH(NCH), .W(W), .DIGITS(DIGITS), .HDISP(HDISP), .VDISP(VDISP),
    .X0(X0), .Y0(Y0), .FG(FG), .BG(BG)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int upd_seen = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [NCH*W-1:0] vals; int tcyc; } upd_t;
  typedef struct { logic [11:0] exp; int px; int py; } pix_t;
  upd_t q_upd[$];
  pix_t q_pix[$];

  // Reference: the numbers currently expected on screen.
  longint model_disp[NCH];

  // Segment masks {a,b,c,d,e,f,g} for decimal digits.
  logic [6:0] seg_tab[10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
  int seg_u0[7] = '{2, 14, 14, 2, 0, 0, 2};
  int seg_u1[7] = '{13, 15, 15, 13, 1, 1, 13};
  int seg_v0[7] = '{0, 2, 13, 22, 13, 2, 11};
  int seg_v1[7] = '{1, 10, 21, 23, 21, 10, 12};
  int pu[9] = '{7, 15, 14, 8, 1, 0, 6, 7, 7};
  int pv[9] = '{0, 5, 17, 23, 15, 6, 11, 5, 26};

  function automatic logic [11:0] ref_pix(int px, int py);
    int r, v, d, u, dig;
    longint p, val;
    logic [6:0] m;
    if (px >= X0 && py >= Y0) begin
      r = (py - Y0) / 32; v = (py - Y0) % 32;
      d = (px - X0) / 16; u = (px - X0) % 16;
      if (r < NCH && d < DIGITS && v < 24) begin
        val = model_disp[r];
        p = 1;
        for (int i = 0; i < DIGITS - 1 - d; i++) p = p * 10;
        dig = int'((val / p) % 10);
        if (val >= p || d == DIGITS - 1) begin
          m = seg_tab[dig];
          for (int s = 0; s < 7; s++)
            if (m[6-s] && u >= seg_u0[s] && u <= seg_u1[s] && v >= seg_v0[s] && v <= seg_v1[s])
              return FG;
        end
      end
    end
    return (px < HDISP && py < VDISP) ? BG : 12'h000;
  endfunction

  // Monitor: compares pixels and update pulses against the queues.
  initial begin
    pix_t p;
    upd_t e;
    logic [63:0] tmp;
    bit prev_upd;
    prev_upd = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (q_pix.size() > 0) begin
        p = q_pix.pop_front();
        total++;
        if (bus.rgb !== p.exp) begin
          bad++;
          $display("FAIL pix(%0d,%0d) rgb=%h expected=%h", p.px, p.py, bus.rgb, p.exp);
        end
      end
      if (prev_upd) begin
        total++;
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_after_swap busy=%b expected=0", bus.busy);
        end
      end
      prev_upd = (bus.update === 1'b1);
      if (bus.update === 1'b1) begin
        upd_seen++;
        total++;
        if (q_upd.size() == 0) begin
          bad++;
          $display("FAIL update_unexpected at cycle %0d, expected none", cyc);
        end else begin
          e = q_upd.pop_front();
          if (cyc - e.tcyc != CONV_CYC) begin
            bad++;
            $display("FAIL update_latency got=%0d expected=%0d", cyc - e.tcyc, CONV_CYC);
          end
          for (int k = 0; k < NCH; k++) begin
            tmp = '0;
            tmp[W-1:0] = e.vals[k*W +: W];
            model_disp[k] = longint'(tmp);
          end
        end
      end
    end
  end

  task automatic park();
    bus.x = 11'(HDISP + 20);
    bus.y = 11'd5;
  endtask

  task automatic probe(int px, int py);
    pix_t e;
    bus.x = 11'(px); bus.y = 11'(py);
    e.exp = ref_pix(px, py); e.px = px; e.py = py;
    q_pix.push_back(e);
    @(negedge clk);
  endtask

  task automatic probe_const(int px, int py, logic [11:0] exp);
    pix_t e;
    bus.x = 11'(px); bus.y = 11'(py);
    e.exp = exp; e.px = px; e.py = py;
    q_pix.push_back(e);
    @(negedge clk);
  endtask

  task automatic probe_rows();
    for (int r = 0; r < NCH; r++)
      for (int d = 0; d < DIGITS; d++)
        for (int k = 0; k < 9; k++)
          probe(X0 + 16*d + pu[k], Y0 + 32*r + pv[k]);
    for (int i = 0; i < 150; i++)
      probe($urandom_range(799, 0), $urandom_range(524, 0));
    park();
    @(negedge clk);
  endtask

  // A trigger is accepted iff freeze is low and no conversion is outstanding.
  task automatic trigger(int hold);
    upd_t e;
    bit acc, pend;
    pend = (q_upd.size() != 0);
    acc = !bus.freeze && !pend;
    bus.x = 11'd0; bus.y = 11'(VDISP);
    if (acc) begin
      e.vals = bus.counts; e.tcyc = cyc + 1;
      q_upd.push_back(e);
    end
    @(negedge clk);
    total++;
    if (bus.busy !== (acc || pend)) begin
      bad++;
      $display("FAIL busy_after_trigger busy=%b expected=%b", bus.busy, acc || pend);
    end
    repeat (hold - 1) @(negedge clk);
    park();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q_upd.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q_upd.size() != 0) begin
      bad++;
      $display("FAIL update_timeout pending=%0d expected=0", q_upd.size());
      q_upd.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_counts();
    for (int k = 0; k < NCH; k++)
      bus.counts[k*W +: W] = $urandom() >> $urandom_range(31, 0);
  endtask

  initial begin
    int u0;
    for (int k = 0; k < NCH; k++) model_disp[k] = 0;
    reset = 1'b1;
    bus.freeze = 1'b0;
    bus.counts = '0;
    park();
    repeat (3) @(negedge clk);
    total++;
    if (bus.rgb !== 12'h000 || bus.busy !== 1'b0 || bus.update !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rgb=%h busy=%b update=%b expected 000/0/0", bus.rgb, bus.busy, bus.update);
    end
    reset = 1'b0;
    @(negedge clk);

    // all-zero display after reset, and no update without a trigger
    probe_rows();
    repeat (400) @(negedge clk);
    total++;
    if (upd_seen != 0) begin
      bad++;
      $display("FAIL no_update_before_trigger updates=%0d expected=0", upd_seen);
    end

    // directed values
    rand_counts();
    bus.counts[0*W +: W] = 32'd1234567890;
    bus.counts[1*W +: W] = 32'hFFFFFFFF;
    bus.counts[2*W +: W] = 32'd7;
    trigger(1);
    wait_idle();
    probe_const(X0 + 16*9 + 15, Y0 + 64 + 5, FG);
    probe_const(X0 + 16*8 + 15, Y0 + 64 + 5, BG);
    probe_const(X0 + 0, Y0 + 32 + 6, FG);
    probe_const(X0 + 7, Y0 + 32 + 0, BG);
    probe_rows();

    // random frames; counts change mid-conversion must not leak through
    for (int f = 0; f < 3; f++) begin
      rand_counts();
      trigger(1);
      repeat (5) @(negedge clk);
      rand_counts();
      wait_idle();
      probe_rows();
    end

    // held trigger position and retrigger while busy
    u0 = upd_seen;
    rand_counts();
    trigger(4);
    rand_counts();
    repeat (20) @(negedge clk);
    trigger(1);
    wait_idle();
    total++;
    if (upd_seen - u0 != 1) begin
      bad++;
      $display("FAIL single_update updates=%0d expected=1", upd_seen - u0);
    end
    probe_rows();

    // freeze holds the display across two triggers
    u0 = upd_seen;
    bus.freeze = 1'b1;
    rand_counts();
    trigger(1);
    repeat (400) @(negedge clk);
    rand_counts();
    trigger(1);
    repeat (400) @(negedge clk);
    total++;
    if (upd_seen != u0) begin
      bad++;
      $display("FAIL freeze_no_update updates=%0d expected=0", upd_seen - u0);
    end
    probe_rows();
    bus.freeze = 1'b0;
    trigger(1);
    wait_idle();
    probe_rows();

    // freeze rising mid-conversion still completes
    rand_counts();
    trigger(1);
    repeat (50) @(negedge clk);
    bus.freeze = 1'b1;
    wait_idle();
    bus.freeze = 1'b0;
    probe_rows();

    // reset in the middle of channel 4's conversion
    rand_counts();
    trigger(1);
    repeat (4 * (W + 2) + 10) @(negedge clk);
    reset = 1'b1;
    q_upd.delete();
    for (int k = 0; k < NCH; k++) model_disp[k] = 0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.rgb !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid_conv busy=%b rgb=%h expected 0/000", bus.busy, bus.rgb);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    probe_rows();
    rand_counts();
    trigger(1);
    wait_idle();
    probe_rows();

    repeat (5) @(negedge clk);
    total++;
    if (q_pix.size() != 0) begin
      bad++;
      $display("FAIL pixel_queue_drain left=%0d expected=0", q_pix.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
